// File: rtl/rx_frame_buffer_pkg.sv
// ----------------------------------------------------------------------------
// rx_frame_buffer_pkg : shared state encoding and constants for the rx buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rx_frame_buffer_pkg;

  localparam int DROP_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage : rx_frame_buffer_pkg

`default_nettype wire

// File: rtl/rx_frame_buffer_mem.sv
// ----------------------------------------------------------------------------
// rx_frame_buffer_mem : DEPTH x DATA_WIDTH 1W/1R synchronous RAM, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_frame_buffer_mem
  import rx_frame_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array kept reset-free so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : rx_frame_buffer_mem

`default_nettype wire

// File: rtl/rx_frame_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// rx_frame_buffer_ctrl : buffers one rx frame, drops bad ones, hands it out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_frame_buffer_ctrl
  import rx_frame_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_soc,
  input  logic                  in_eoc,
  input  logic                  in_error,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [2:0]            in_data_bits,
  output logic                  frame_valid,
  output logic [CW-1:0]         frame_bytes,
  output logic [2:0]            frame_last_bits,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  frame_release,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]          last_bits_q, last_bits_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                drop_inc;
  logic                mem_we;
  logic                mem_re;
  logic                room;

  assign room = (count_q < DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      last_bits_q <= '0;
      drop_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      last_bits_q <= last_bits_d;
      drop_q      <= drop_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    last_bits_d = last_bits_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    drop_inc    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_soc && enable) begin
          state_d = RECV;
          count_d = '0;
        end
      end

      RECV: begin
        if (in_soc) begin
          count_d  = '0;
          drop_inc = 1'b1;
        end else if (in_eoc) begin
          if (in_error) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end else if (in_data_valid) begin
            if (room) begin
              mem_we      = 1'b1;
              count_d     = count_q + CW'(1);
              last_bits_d = in_data_bits;
              rd_ptr_d    = '0;
              state_d     = HOLD;
            end else begin
              state_d  = IDLE;
              drop_inc = 1'b1;
            end
          end else if (count_q == '0) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end else begin
            last_bits_d = 3'd0;
            rd_ptr_d    = '0;
            state_d     = HOLD;
          end
        end else if (in_error) begin
          state_d  = DISCARD;
          drop_inc = 1'b1;
        end else if (in_data_valid) begin
          if (room) begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            state_d  = DISCARD;
            drop_inc = 1'b1;
          end
        end
      end

      DISCARD: begin
        if (in_soc) begin
          state_d = RECV;
          count_d = '0;
        end else if (in_eoc) begin
          state_d = IDLE;
        end
      end

      HOLD: begin
        if (rd_en && (rd_ptr_q != count_q)) begin
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_ptr_q == count_q - CW'(1));
          rd_ptr_d   = rd_ptr_q + CW'(1);
        end
        // A release may hand straight over to the next frame's soc.
        if (frame_release) begin
          rd_ptr_d    = '0;
          last_bits_d = 3'd0;
          if (in_soc && enable) begin
            state_d = RECV;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (in_soc) begin
          drop_inc = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    drop_d = (drop_inc && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
  end

  rx_frame_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (in_data),
    .re_i    (mem_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign frame_valid     = (state_q == HOLD);
  assign frame_bytes     = (state_q == HOLD) ? count_q : '0;
  assign frame_last_bits = last_bits_q;
  assign rd_valid        = rd_valid_q;
  assign rd_last         = rd_last_q;
  assign busy            = (state_q != IDLE);
  assign drop_count      = drop_q;

`ifndef SYNTHESIS
  a_soc_exclusive: assert property (@(posedge clk) disable iff (rst)
    in_soc |-> !(in_eoc || in_error || in_data_valid));
  a_eoc_partial: assert property (@(posedge clk) disable iff (rst)
    (in_eoc && in_data_valid) |-> (in_data_bits != 3'd0));
`endif

endmodule : rx_frame_buffer_ctrl

`default_nettype wire

// File: tb/tb_rx_frame_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rx_frame_buffer_ctrl : directed self-checking bench for rx_frame_buffer_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rx_frame_buffer_ctrl;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int CW         = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic                  in_soc;
  logic                  in_eoc;
  logic                  in_error;
  logic                  in_data_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [2:0]            in_data_bits;
  logic                  frame_valid;
  logic [CW-1:0]         frame_bytes;
  logic [2:0]            frame_last_bits;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  frame_release;
  logic                  busy;
  logic [7:0]            drop_count;

  int checks;
  int errors;

  rx_frame_buffer_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .in_soc          (in_soc),
    .in_eoc          (in_eoc),
    .in_error        (in_error),
    .in_data_valid   (in_data_valid),
    .in_data         (in_data),
    .in_data_bits    (in_data_bits),
    .frame_valid     (frame_valid),
    .frame_bytes     (frame_bytes),
    .frame_last_bits (frame_last_bits),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_last         (rd_last),
    .frame_release   (frame_release),
    .busy            (busy),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Outputs are sampled 1 time unit after the edge that produced them.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_soc        = 1'b0;
    in_eoc        = 1'b0;
    in_error      = 1'b0;
    in_data_valid = 1'b0;
    in_data       = '0;
    in_data_bits  = 3'd0;
  endtask

  task automatic ev_soc();
    in_soc = 1'b1; cyc(); idle_in();
  endtask

  task automatic ev_byte(input logic [7:0] b);
    in_data_valid = 1'b1; in_data = b; cyc(); idle_in();
  endtask

  task automatic ev_eoc();
    in_eoc = 1'b1; cyc(); idle_in();
  endtask

  task automatic ev_err();
    in_error = 1'b1; cyc(); idle_in();
  endtask

  task automatic ev_partial(input logic [7:0] b, input logic [2:0] bits);
    in_eoc = 1'b1; in_data_valid = 1'b1; in_data = b; in_data_bits = bits;
    cyc(); idle_in();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %0h exp 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    checks++; if (frame_bytes !== '0) begin errors++; $display("FAIL reset_frame_bytes got %0d exp 0", frame_bytes); end
    checks++; if ({rd_valid, rd_last, rd_data, frame_last_bits} !== '0) begin errors++; $display("FAIL reset_rd got v=%0h l=%0h d=%0h lb=%0d exp all 0", rd_valid, rd_last, rd_data, frame_last_bits); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_good_frame();
    ev_soc(); ev_byte(8'h93); ev_byte(8'h20); ev_eoc();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_frame_valid got %0h exp 1", frame_valid); end
    checks++; if (frame_bytes !== CW'(2)) begin errors++; $display("FAIL good_frame_bytes got %0d exp 2", frame_bytes); end
    checks++; if (frame_last_bits !== 3'd0) begin errors++; $display("FAIL good_last_bits got %0d exp 0", frame_last_bits); end
    rd_en = 1'b1;
    cyc();
    checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b0, 8'h93}) begin errors++; $display("FAIL good_rd0 got v=%0h l=%0h d=%0h exp v=1 l=0 d=93", rd_valid, rd_last, rd_data); end
    cyc();
    rd_en = 1'b0;
    checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 8'h20}) begin errors++; $display("FAIL good_rd1 got v=%0h l=%0h d=%0h exp v=1 l=1 d=20", rd_valid, rd_last, rd_data); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL good_rd_past_end got v=%0h exp 0", rd_valid); end
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    checks++; if ({busy, frame_valid} !== 2'b00) begin errors++; $display("FAIL good_release got busy=%0h fv=%0h exp 0 0", busy, frame_valid); end
    checks++; if (frame_bytes !== '0) begin errors++; $display("FAIL good_release_bytes got %0d exp 0", frame_bytes); end
  endtask

  task automatic test_short_frame();
    ev_soc(); ev_partial(8'h26, 3'd7);
    checks++; if ({frame_valid, frame_bytes} !== {1'b1, CW'(1)}) begin errors++; $display("FAIL short_frame got fv=%0h bytes=%0d exp 1 1", frame_valid, frame_bytes); end
    checks++; if (frame_last_bits !== 3'd7) begin errors++; $display("FAIL short_last_bits got %0d exp 7", frame_last_bits); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 8'h26}) begin errors++; $display("FAIL short_rd got v=%0h l=%0h d=%0h exp v=1 l=1 d=26", rd_valid, rd_last, rd_data); end
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    checks++; if ({busy, frame_last_bits} !== 4'b0) begin errors++; $display("FAIL short_release got busy=%0h lb=%0d exp 0 0", busy, frame_last_bits); end
  endtask

  task automatic test_error();
    ev_soc(); ev_byte(8'h50); ev_err();
    checks++; if ({busy, frame_valid, drop_count} !== {1'b1, 1'b0, 8'd1}) begin errors++; $display("FAIL err_discard got busy=%0h fv=%0h drop=%0d exp 1 0 1", busy, frame_valid, drop_count); end
    ev_eoc();
    checks++; if ({busy, frame_valid} !== 2'b00) begin errors++; $display("FAIL err_to_idle got busy=%0h fv=%0h exp 0 0", busy, frame_valid); end
    ev_soc(); ev_byte(8'h11); ev_eoc();
    checks++; if ({frame_valid, frame_bytes} !== {1'b1, CW'(1)}) begin errors++; $display("FAIL err_next_frame got fv=%0h bytes=%0d exp 1 1", frame_valid, frame_bytes); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h11}) begin errors++; $display("FAIL err_next_rd got v=%0h d=%0h exp v=1 d=11", rd_valid, rd_data); end
    frame_release = 1'b1; cyc(); frame_release = 1'b0;
  endtask

  task automatic test_overflow();
    ev_soc();
    for (int i = 0; i < DEPTH + 1; i++) ev_byte(8'(i));
    checks++; if ({busy, drop_count} !== {1'b1, 8'd2}) begin errors++; $display("FAIL ovf_discard got busy=%0h drop=%0d exp 1 2", busy, drop_count); end
    ev_eoc();
    checks++; if ({busy, frame_valid} !== 2'b00) begin errors++; $display("FAIL ovf_idle got busy=%0h fv=%0h exp 0 0", busy, frame_valid); end
    ev_soc();
    for (int i = 0; i < DEPTH; i++) ev_byte(8'hC0 + 8'(i));
    ev_eoc();
    checks++; if ({frame_valid, frame_bytes, drop_count} !== {1'b1, CW'(16), 8'd2}) begin errors++; $display("FAIL full_frame got fv=%0h bytes=%0d drop=%0d exp 1 16 2", frame_valid, frame_bytes, drop_count); end
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      checks++;
      if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == DEPTH - 1), 8'hC0 + 8'(i)}) begin
        errors++;
        $display("FAIL full_rd[%0d] got v=%0h l=%0h d=%0h exp v=1 l=%0h d=%0h", i, rd_valid, rd_last, rd_data, (i == DEPTH - 1), 8'hC0 + 8'(i));
      end
    end
    rd_en = 1'b0;
    frame_release = 1'b1; cyc(); frame_release = 1'b0;
  endtask

  task automatic test_hold();
    ev_soc(); ev_byte(8'h5A); ev_eoc();
    ev_soc(); ev_byte(8'h77); ev_eoc();
    checks++; if ({frame_valid, frame_bytes, drop_count} !== {1'b1, CW'(1), 8'd3}) begin errors++; $display("FAIL hold_ignore got fv=%0h bytes=%0d drop=%0d exp 1 1 3", frame_valid, frame_bytes, drop_count); end
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    checks++; if ({rd_valid, rd_last, rd_data} !== {1'b1, 1'b1, 8'h5A}) begin errors++; $display("FAIL hold_rd got v=%0h l=%0h d=%0h exp v=1 l=1 d=5a", rd_valid, rd_last, rd_data); end
    frame_release = 1'b1; in_soc = 1'b1;
    cyc();
    frame_release = 1'b0; in_soc = 1'b0;
    checks++; if ({busy, frame_valid, drop_count} !== {1'b1, 1'b0, 8'd3}) begin errors++; $display("FAIL hold_release_soc got busy=%0h fv=%0h drop=%0d exp 1 0 3", busy, frame_valid, drop_count); end
    ev_byte(8'hAA); ev_eoc();
    checks++; if ({frame_valid, frame_bytes} !== {1'b1, CW'(1)}) begin errors++; $display("FAIL hold_new_frame got fv=%0h bytes=%0d exp 1 1", frame_valid, frame_bytes); end
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL hold_new_rd got v=%0h d=%0h exp v=1 d=aa", rd_valid, rd_data); end
    frame_release = 1'b1; cyc(); frame_release = 1'b0;
  endtask

  task automatic test_enable();
    enable = 1'b0;
    ev_soc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_off_soc got busy=%0h exp 0", busy); end
    ev_byte(8'h12); ev_eoc();
    checks++; if ({busy, frame_valid, drop_count} !== {1'b0, 1'b0, 8'd3}) begin errors++; $display("FAIL enable_off_frame got busy=%0h fv=%0h drop=%0d exp 0 0 3", busy, frame_valid, drop_count); end
    enable = 1'b1;
  endtask

  task automatic test_rst_mid();
    ev_soc(); ev_byte(8'h01);
    rst = 1'b1; cyc(); rst = 1'b0;
    checks++; if ({busy, frame_valid, drop_count} !== {1'b0, 1'b0, 8'd0}) begin errors++; $display("FAIL rst_recv got busy=%0h fv=%0h drop=%0d exp 0 0 0", busy, frame_valid, drop_count); end
    ev_soc(); ev_byte(8'h33); ev_byte(8'h44); ev_eoc();
    rd_en = 1'b1; cyc();
    checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h33}) begin errors++; $display("FAIL rst_pre_rd got v=%0h d=%0h exp v=1 d=33", rd_valid, rd_data); end
    rst = 1'b1; cyc(); rst = 1'b0; rd_en = 1'b0;
    checks++; if ({busy, frame_valid, frame_bytes, frame_last_bits} !== '0) begin errors++; $display("FAIL rst_read_state got busy=%0h fv=%0h bytes=%0d lb=%0d exp all 0", busy, frame_valid, frame_bytes, frame_last_bits); end
    checks++; if ({rd_valid, rd_last, rd_data} !== '0) begin errors++; $display("FAIL rst_read_out got v=%0h l=%0h d=%0h exp all 0", rd_valid, rd_last, rd_data); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) begin ev_soc(); ev_eoc(); end
    checks++; if ({busy, drop_count} !== {1'b0, 8'd10}) begin errors++; $display("FAIL empty_drops got busy=%0h drop=%0d exp 0 10", busy, drop_count); end
    for (int i = 0; i < 250; i++) begin ev_soc(); ev_eoc(); end
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d exp 255", drop_count); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    enable        = 1'b1;
    rd_en         = 1'b0;
    frame_release = 1'b0;
    idle_in();
    test_reset();
    test_good_frame();
    test_short_frame();
    test_error();
    test_overflow();
    test_hold();
    test_enable();
    test_rst_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rx_frame_buffer_ctrl

`default_nettype wire
